// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS definitions: sync headers, descrambler taps, block-lock states.
// Imported by the 64b/66b RX block and the reusable lock FSM.
package pcs_pkg;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   // x^58 + x^39 + 1: taps are 39 and 58 bits back, i.e. history indices 38 and 57
   localparam int SCR_I0 = 38;
   localparam int SCR_I1 = 57;
   localparam int SCR_W  = 58;

   typedef enum logic [1:0] {
      ST_UNLOCKED,
      ST_LOCKED,
      ST_SLIP
   } lock_state_t;

   function automatic logic sync_good(input logic [1:0] h);
      return (h == SYNC_DATA) || (h == SYNC_CTRL);
   endfunction

endpackage

// File: rtl/_64b66b_rx_lock_fsm.sv
// Block-lock state machine: counts good/bad sync headers and requests slips.
// lock is registered from the state; slip is high for the single SLIP cycle.
module _64b66b_rx_lock_fsm
   import pcs_pkg::*;
#(
   parameter int LOCK_CNT = 64,
   parameter int INV_MAX  = 16
) (
   input  logic clk,
   input  logic nreset,
   input  logic hdr_evt,
   input  logic hdr_good,
   output logic lock,
   output logic slip
);

   localparam int SW = $clog2(LOCK_CNT + 1);
   localparam int IW = $clog2(INV_MAX + 1);

   lock_state_t   state, state_nx;
   logic [SW-1:0] sh_cnt, sh_nx, sh_inc;
   logic [IW-1:0] inv_cnt, inv_nx, inv_inc;

   // saturating increments
   assign sh_inc  = (sh_cnt  == SW'(LOCK_CNT)) ? sh_cnt  : sh_cnt  + 1'b1;
   assign inv_inc = (inv_cnt == IW'(INV_MAX))  ? inv_cnt : inv_cnt + 1'b1;

   always_comb begin
      state_nx = state;
      sh_nx    = sh_cnt;
      inv_nx   = inv_cnt;
      case (state)
         ST_UNLOCKED: begin
            if (hdr_evt) begin
               if (hdr_good) begin
                  sh_nx = sh_inc;
                  if (sh_inc == SW'(LOCK_CNT)) begin
                     state_nx = ST_LOCKED;
                     sh_nx    = '0;
                     inv_nx   = '0;
                  end
               end else begin
                  state_nx = ST_SLIP;
               end
            end
         end
         ST_LOCKED: begin
            if (hdr_evt) begin
               sh_nx  = sh_inc;
               inv_nx = hdr_good ? inv_cnt : inv_inc;
               // too many invalid headers wins over a window ending on the same header
               if (inv_nx >= IW'(INV_MAX)) begin
                  state_nx = ST_SLIP;
               end else if (sh_nx >= SW'(LOCK_CNT)) begin
                  sh_nx  = '0;
                  inv_nx = '0;
               end
            end
         end
         ST_SLIP: begin
            state_nx = ST_UNLOCKED;
            sh_nx    = '0;
            inv_nx   = '0;
         end
         default: begin
            state_nx = ST_UNLOCKED;
            sh_nx    = '0;
            inv_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state   <= ST_UNLOCKED;
         sh_cnt  <= '0;
         inv_cnt <= '0;
         lock    <= 1'b0;
      end else begin
         state   <= state_nx;
         sh_cnt  <= sh_nx;
         inv_cnt <= inv_nx;
         lock    <= (state == ST_LOCKED);
      end
   end

   assign slip = (state == ST_SLIP);

endmodule

// File: rtl/_64b66b_rx.sv
// 10GBASE-R RX 64b/66b: self-synchronizing descrambler plus block-lock, 1-cycle datapath.
// No backpressure; valid_i=0 cycles hold the descrambler history and data_o.
module _64b66b_rx
   import pcs_pkg::*;
#(
   parameter int LEN      = 32,
   parameter int LOCK_CNT = 64,
   parameter int INV_MAX  = 16
) (
   input  logic           clk,
   input  logic           nreset,
   input  logic           valid_i,
   input  logic           head_v_i,
   input  logic [1:0]     head_i,
   input  logic [LEN-1:0] data_i,
   output logic           valid_o,
   output logic           head_v_o,
   output logic [1:0]     head_o,
   output logic [LEN-1:0] data_o,
   output logic           lock_o,
   output logic           slip_o
);

   logic [SCR_W-1:0]     s_q, s_nx;
   logic [LEN+SCR_W-1:0] x;
   logic [LEN-1:0]       d;

   // x is the received line stream in arrival order: history in [SCR_W-1:0], current word above it
   always_comb begin
      x = {data_i, {SCR_W{1'b0}}};
      for (int k = 0; k < SCR_W; k++) begin
         x[SCR_W-1-k] = s_q[k];
      end
      d = '0;
      for (int i = 0; i < LEN; i++) begin
         d[i] = x[i+SCR_W] ^ x[i+SCR_W-1-SCR_I0] ^ x[i+SCR_W-1-SCR_I1];
      end
      s_nx = '0;
      for (int k = 0; k < SCR_W; k++) begin
         s_nx[k] = x[LEN+SCR_W-1-k];
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         s_q      <= '1;
         valid_o  <= 1'b0;
         head_v_o <= 1'b0;
         head_o   <= '0;
         data_o   <= '0;
      end else begin
         valid_o  <= valid_i;
         head_v_o <= valid_i & head_v_i;
         if (valid_i) begin
            s_q    <= s_nx;
            data_o <= d;
            head_o <= head_i;
         end
      end
   end

   _64b66b_rx_lock_fsm #(
      .LOCK_CNT (LOCK_CNT),
      .INV_MAX  (INV_MAX)
   ) u_lock_fsm (
      .clk      (clk),
      .nreset   (nreset),
      .hdr_evt  (valid_i & head_v_i),
      .hdr_good (sync_good(head_i)),
      .lock     (lock_o),
      .slip     (slip_o)
   );

endmodule

// File: tb/tb__64b66b_rx.sv
// Directed bench for _64b66b_rx: serial TX scrambler reference, lock/slip sequences, bubbles, reset.
module tb__64b66b_rx;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        valid_i = 1'b0;
   logic        head_v_i = 1'b0;
   logic [1:0]  head_i = 2'b00;
   logic [31:0] data_i = '0;
   logic        valid_o, head_v_o, lock_o, slip_o;
   logic [1:0]  head_o;
   logic [31:0] data_o;

   int          n_chk = 0;
   int          n_err = 0;
   int          hdr_cnt = 0;
   logic [57:0] sc;

   _64b66b_rx #(.LEN(32), .LOCK_CNT(64), .INV_MAX(16)) dut (
      .clk      (clk),
      .nreset   (nreset),
      .valid_i  (valid_i),
      .head_v_i (head_v_i),
      .head_i   (head_i),
      .data_i   (data_i),
      .valid_o  (valid_o),
      .head_v_o (head_v_o),
      .head_o   (head_o),
      .data_o   (data_o),
      .lock_o   (lock_o),
      .slip_o   (slip_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // serial scrambler, bit 0 first on the line, sc[0] = most recent output bit
   task automatic tx_scr(input logic [31:0] p, output logic [31:0] s);
      logic o;
      s = '0;
      for (int i = 0; i < 32; i++) begin
         o    = p[i] ^ sc[38] ^ sc[57];
         s[i] = o;
         sc   = {sc[56:0], o};
      end
   endtask

   task automatic do_reset();
      nreset = 1'b0; valid_i = 1'b0; head_v_i = 1'b0;
      step();
      chk("rst.valid_o", valid_o, 0);
      chk("rst.head_v_o", head_v_o, 0);
      chk("rst.head_o", head_o, 0);
      chk("rst.data_o", data_o, 0);
      chk("rst.lock_o", lock_o, 0);
      chk("rst.slip_o", slip_o, 0);
      nreset = 1'b1;
      hdr_cnt = 0;
   endtask

   task automatic send_hdr(input logic [1:0] h);
      valid_i = 1'b1; head_v_i = 1'b1; head_i = h; data_i = $urandom;
      step();
   endtask

   task automatic idle();
      valid_i = 1'b0; head_v_i = 1'b0;
      step();
   endtask

   // headers on even words alternating 01/10; lock_o expected from headers taken before this cycle
   task automatic run_stream(input int nwords, input bit bub_en, input logic [57:0] seed,
                             input int skip, input string tag);
      logic [31:0] p, s, last_p;
      bit          last_ok, exp_lock;
      int          w, cyc;
      sc = seed; w = 0; cyc = 0; last_ok = 0; last_p = '0;
      while (w < nwords) begin
         exp_lock = (hdr_cnt >= 64);
         if (bub_en && (cyc % 3 == 2)) begin
            valid_i = 1'b0; head_v_i = 1'b0;
            step();
            chk({tag, ".bub_valid"}, valid_o, 0);
            if (last_ok) chk({tag, ".bub_hold"}, data_o, last_p);
         end else begin
            p = $urandom;
            tx_scr(p, s);
            valid_i  = 1'b1;
            head_v_i = (w % 2 == 0);
            head_i   = (w % 4 == 0) ? 2'b01 : 2'b10;
            data_i   = s;
            if (head_v_i) hdr_cnt++;
            step();
            chk({tag, ".valid_o"}, valid_o, 1);
            chk({tag, ".head_v_o"}, head_v_o, (w % 2 == 0));
            if (w % 2 == 0) chk({tag, ".head_o"}, head_o, (w % 4 == 0) ? 2'b01 : 2'b10);
            if (w >= skip) chk({tag, ".data_o"}, data_o, p);
            last_p  = p;
            last_ok = (w >= skip);
            w++;
         end
         chk({tag, ".lock_o"}, lock_o, exp_lock);
         chk({tag, ".slip_o"}, slip_o, 0);
         cyc++;
      end
      valid_i = 1'b0; head_v_i = 1'b0;
   endtask

   initial begin
      step();
      do_reset();

      // clean stream, matching seeds
      run_stream(200, 1'b0, '1, 0, "s1");

      // reset for one cycle while locked, then relock
      chk("mid.lock_before", lock_o, 1);
      nreset = 1'b0; valid_i = 1'b1; head_v_i = 1'b1; head_i = 2'b01; data_i = $urandom;
      step();
      chk("mid.lock_o", lock_o, 0);
      chk("mid.slip_o", slip_o, 0);
      chk("mid.valid_o", valid_o, 0);
      nreset = 1'b1;
      repeat (63) send_hdr(2'b10);
      chk("mid.lock_63", lock_o, 0);
      send_hdr(2'b01);
      chk("mid.lock_64", lock_o, 0);
      idle();
      chk("mid.relock", lock_o, 1);

      // transmitter seed differs from receiver reset seed: first two words are don't-care
      do_reset();
      run_stream(200, 1'b0, '0, 2, "s2");

      // bubbles every third cycle
      do_reset();
      run_stream(200, 1'b1, '1, 0, "s5");

      // bad header while unlocked; header during SLIP must be ignored
      do_reset();
      repeat (10) send_hdr(2'b01);
      chk("s3.slip_pre", slip_o, 0);
      send_hdr(2'b11);
      chk("s3.slip", slip_o, 1);
      chk("s3.lock", lock_o, 0);
      send_hdr(2'b10);
      chk("s3.slip_one", slip_o, 0);
      repeat (63) send_hdr(2'b01);
      idle();
      chk("s3.lock_63", lock_o, 0);
      send_hdr(2'b10);
      chk("s3.lock_64", lock_o, 0);
      idle();
      chk("s3.lock", lock_o, 1);

      // 15 bad in a window keeps lock, window clears; 16 in the next window slips
      repeat (49) send_hdr(2'b01);
      repeat (15) send_hdr(2'b00);
      chk("s4.w1_slip", slip_o, 0);
      idle();
      chk("s4.w1_lock", lock_o, 1);
      repeat (15) send_hdr(2'b11);
      chk("s4.w2_slip15", slip_o, 0);
      chk("s4.w2_lock15", lock_o, 1);
      send_hdr(2'b01);
      send_hdr(2'b00);
      chk("s4.slip16", slip_o, 1);
      chk("s4.lock16", lock_o, 1);
      idle();
      chk("s4.lock_drop", lock_o, 0);
      chk("s4.slip_end", slip_o, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/_64b66b_rx.md
Name: _64b66b_rx

Overview:
- Receive-side 64b/66b block for the 10GBASE-R PCS.
- Takes scrambled payload words and 2-bit sync headers from the RX gearbox. Descrambles the payload with the self-synchronizing polynomial x^58+x^39+1. Runs the block-lock state machine on the sync headers.
- Drives a slip request back to the gearbox. Sits between the RX gearbox and the 64b/66b decoder.

Parameters:
- LEN, 32, payload bits per word; legal values are 32 or 64. With 32, one 64-bit block spans 2 words and the header arrives with the first word.
- LOCK_CNT, 64, consecutive valid headers needed to acquire lock; also the window length while locked.
- INV_MAX, 16, invalid headers within one LOCK_CNT window that cause loss of lock.

Ports:
- clk  in  1  clock
- nreset  in  1  reset, synchronous, active-low
- valid_i  in  1  data_i is valid this cycle
- head_v_i  in  1  head_i is valid this cycle (first word of block); only sampled when valid_i=1
- head_i  in  2  sync header, bit 0 first on the line
- data_i  in  LEN  scrambled payload, bit 0 first on the line
- valid_o  out  1  data_o valid
- head_v_o  out  1  head_o valid
- head_o  out  2  registered copy of head_i
- data_o  out  LEN  descrambled payload
- lock_o  out  1  block lock achieved
- slip_o  out  1  single-cycle request to the gearbox to shift alignment by 1 bit

Behaviour:
- Reset (nreset=0 at posedge clk):
  - all outputs 0
  - FSM = UNLOCKED, sh_cnt=0, inv_cnt=0
  - descrambler state s_q (58 bits) = all 1's
- Descrambler state:
  - s_q[k] holds the received scrambled bit k+1 positions before data_i[0]; s_q[0] is the last bit of the previous valid word.
- Descrambler equations, per bit i:
  - i<=38: d[i] = data_i[i] ^ s_q[38-i] ^ s_q[57-i]
  - 39<=i<=57: d[i] = data_i[i] ^ data_i[i-39] ^ s_q[57-i]
  - i>=58: d[i] = data_i[i] ^ data_i[i-39] ^ data_i[i-58]
- The descrambler uses received (scrambled) bits only, so there is no combinational chain through d.
- s_q update, only when valid_i=1:
  - LEN=32: s_q[k] = data_i[31-k] for k<32, else s_q[k-32]
  - LEN=64: s_q[k] = data_i[63-k]
- When valid_i=0, s_q holds.
- The descrambler runs regardless of lock state. It self-synchronizes after 58 received bits.
- Datapath latency is exactly 1 cycle:
  - valid_o, head_v_o, head_o, data_o are registered from the same-cycle inputs and d.
  - head_v_o = valid_i & head_v_i.
  - When valid_i=0: valid_o=0 and data_o holds its previous value.
- Header evaluation event E = valid_i & head_v_i. A header is good iff head_i is 2'b01 or 2'b10; 00 and 11 are bad.
- FSM, evaluated only on E, except SLIP:
  - UNLOCKED, good header: sh_cnt++. If sh_cnt reaches LOCK_CNT: go to LOCKED, clear both counters.
  - UNLOCKED, bad header: go to SLIP.
  - LOCKED, any header: sh_cnt++. A bad header also does inv_cnt++.
  - LOCKED, inv_cnt reaches INV_MAX: go to SLIP. This takes priority over window end on the same header.
  - LOCKED, sh_cnt reaches LOCK_CNT with inv_cnt<INV_MAX: clear both counters, stay LOCKED.
  - SLIP: lasts exactly 1 cycle. Clears counters, then goes to UNLOCKED. Any E during SLIP is ignored.
- Output timing:
  - lock_o = registered (state==LOCKED); it rises the cycle after the transition.
  - slip_o = 1 exactly in the cycle the FSM is in SLIP.
- Counter widths are clog2(LOCK_CNT+1) and clog2(INV_MAX+1). Counters saturate and never wrap.
- Reset mid-operation takes effect on the next posedge and overrides all else. lock_o and slip_o are 0 the following cycle.

Decomposition:
- Shared package pcs_pkg: sync header constants (SYNC_DATA=2'b01, SYNC_CTRL=2'b10), scrambler taps I0=38 and I1=57, state width 58.
- One sub-module, _64b66b_rx_lock_fsm (FSM plus counters), so it can be reused by the 25G/40G PCS lanes.
- The descrambler stays inline.

Test Plan:
- Reset then 200 words: TX scrambler model (seed all 1's, LEN=32) scrambles random payload with headers alternating 01/10 on even words.
  - data_o equals the original payload from the first word, with 1-cycle latency.
  - lock_o rises exactly 1 cycle after the FSM takes its 64th good header; slip_o stays 0 throughout.
- RX seed corrupted to 0, same stream.
  - The first 2 words may mismatch; from word index 2 (58 bits received) onward, data_o is bit-exact.
- While UNLOCKED after 10 good headers, inject head_i=2'b11.
  - slip_o=1 for exactly one cycle, counters reset.
  - 64 further good headers are then needed for lock_o=1.
- While LOCKED, inject 15 bad headers in a 64-header window.
  - lock_o stays 1; the window clears.
  - Then inject 16 bad headers within the next window: slip_o pulses on the 16th, and lock_o drops the next cycle.
- Insert valid_i=0 bubbles every 3rd cycle in scenario 1.
  - Output matches, s_q holds across bubbles, valid_o=0 in bubble+1 cycles.
- Assert nreset=0 for one cycle mid-stream while LOCKED.
  - Next cycle: lock_o=0, slip_o=0, valid_o=0.
  - Relock after 64 good headers.
